// File: rtl/scoreboard_pkg.sv
// Shared types and segment constants for the two-digit multiplexed 7-segment driver.
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
package scoreboard_pkg;

   typedef enum logic [1:0] {
      BLANK_T = 2'd0,
      SHOW_T  = 2'd1,
      BLANK_E = 2'd2,
      SHOW_E  = 2'd3
   } state_t;

   localparam logic [6:0] SEG_OFF  = 7'h00;
   localparam logic [6:0] SEG_DASH = 7'h40;

   // Entry 15 first; codes 10..15 are not BCD and show a dash.
   localparam logic [15:0][6:0] SEG_TABLE = {
      SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH,
      7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
      7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   function automatic logic [6:0] seg_decode(input logic [3:0] code);
      return SEG_TABLE[code];
   endfunction

endpackage

// File: rtl/seven_seg_mux_bcd_to_7seg.sv
// Combinational 4-bit code to active-high 7-segment pattern; non-BCD codes show a dash.
module bcd_to_7seg
   import scoreboard_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] seg
);

   assign seg = seg_decode(code);

endmodule

// File: rtl/seven_seg_mux.sv
// Two-digit time-multiplexed 7-segment driver with dead time between digits,
// per-frame digit latching and optional leading-zero suppression.
module seven_seg_mux
   import scoreboard_pkg::*;
#(
   parameter int REFRESH_DIV    = 1000,
   parameter int BLANK_CYCLES   = 16,
   parameter bit SEG_ACTIVE_LOW = 1'b0
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       en_i,
   input  logic [3:0] zehner_i,
   input  logic [3:0] einer_i,
   input  logic       blank_lz_i,
   output logic [6:0] seg_o,
   output logic [1:0] dig_o,
   output logic       frame_o
);

   // state   | meaning
   // BLANK_T | dead time before tens; digits latched on its first cycle
   // SHOW_T  | tens digit driven (or dark when leading zero is suppressed)
   // BLANK_E | dead time before ones
   // SHOW_E  | ones digit driven

   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - BLANK_CYCLES - 1);
   localparam logic [6:0] SEG_DARK = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] slot_last;
   logic [3:0]       tens_q;
   logic [3:0]       ones_q;
   logic             blz_q;
   logic [3:0]       code_sel;
   logic [6:0]       seg_dec;
   logic             tens_dark;

   function automatic logic [6:0] pol(input logic [6:0] seg);
      return SEG_ACTIVE_LOW ? ~seg : seg;
   endfunction

   always_comb begin
      slot_last = SHOW_LAST;
      if (state == BLANK_T || state == BLANK_E) slot_last = BLANK_LAST;
   end

   always_comb begin
      state_next = BLANK_T;
      case (state)
         BLANK_T: state_next = SHOW_T;
         SHOW_T:  state_next = BLANK_E;
         BLANK_E: state_next = SHOW_E;
         SHOW_E:  state_next = BLANK_T;
         default: state_next = BLANK_T;
      endcase
   end

   assign code_sel  = (state == SHOW_E) ? ones_q : tens_q;
   assign tens_dark = blz_q && (tens_q == 4'd0);

   bcd_to_7seg u_dec (
      .code (code_sel),
      .seg  (seg_dec)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state   <= BLANK_T;
         cnt     <= '0;
         tens_q  <= 4'd0;
         ones_q  <= 4'd0;
         blz_q   <= 1'b0;
         dig_o   <= 2'b00;
         seg_o   <= SEG_DARK;
         frame_o <= 1'b0;
      end else if (!en_i) begin
         state   <= BLANK_T;
         cnt     <= '0;
         dig_o   <= 2'b00;
         seg_o   <= SEG_DARK;
         frame_o <= 1'b0;
      end else begin
         frame_o <= 1'b0;
         // Frame start: sample both digits together so they never tear.
         if (state == BLANK_T && cnt == '0) begin
            tens_q  <= zehner_i;
            ones_q  <= einer_i;
            blz_q   <= blank_lz_i;
            frame_o <= 1'b1;
         end

         case (state)
            SHOW_T: begin
               if (tens_dark) begin
                  dig_o <= 2'b00;
                  seg_o <= SEG_DARK;
               end else begin
                  dig_o <= 2'b10;
                  seg_o <= pol(seg_dec);
               end
            end
            SHOW_E: begin
               dig_o <= 2'b01;
               seg_o <= pol(seg_dec);
            end
            default: begin
               dig_o <= 2'b00;
               seg_o <= SEG_DARK;
            end
         endcase

         if (cnt == slot_last) begin
            state <= state_next;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seven_seg_mux.sv
// Directed bench for seven_seg_mux with REFRESH_DIV=8, BLANK_CYCLES=2 (16-cycle frame);
// runs an active-high and an active-low instance side by side on the same inputs.
module tb_seven_seg_mux;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic [3:0] zehner = 4'd0;
   logic [3:0] einer = 4'd0;
   logic       blank_lz = 1'b0;
   logic [6:0] seg, seg_al;
   logic [1:0] dig, dig_al;
   logic       frame, frame_al;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   seven_seg_mux #(.REFRESH_DIV(8), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1'b0)) dut (
      .clk_i(clk), .rst_i(rst), .en_i(en), .zehner_i(zehner), .einer_i(einer),
      .blank_lz_i(blank_lz), .seg_o(seg), .dig_o(dig), .frame_o(frame)
   );

   seven_seg_mux #(.REFRESH_DIV(8), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1'b1)) dut_al (
      .clk_i(clk), .rst_i(rst), .en_i(en), .zehner_i(zehner), .einer_i(einer),
      .blank_lz_i(blank_lz), .seg_o(seg_al), .dig_o(dig_al), .frame_o(frame_al)
   );

   typedef struct {
      logic [3:0] z;
      logic [3:0] e;
      logic       blz;
      logic [1:0] t_dig;
      logic [6:0] t_seg;
      logic [6:0] o_seg;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Compares both instances: {frame, dig, seg, frame_al, dig_al, seg_al}.
   task automatic chk_out(input string name, input logic f, input logic [1:0] d,
                          input logic [6:0] s);
      chk(name, {12'd0, frame, dig, seg, frame_al, dig_al, seg_al},
                {12'd0, f, d, s, f, d, ~s});
   endtask

   task automatic wait_frame(input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (frame) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         errors++;
         checks++;
         $display("FAIL %s: no frame_o within 40 cycles", name);
      end
   endtask

   // Assumes the current negedge is the frame_o cycle (offset 0).
   task automatic check_frame(input string name, input logic [1:0] t_dig,
                              input logic [6:0] t_seg, input logic [6:0] o_seg);
      for (int off = 0; off < 16; off++) begin
         if (off > 0) @(negedge clk);
         if (off < 2)       chk_out(name, off == 0, 2'b00, 7'h00);
         else if (off < 8)  chk_out(name, 1'b0, t_dig, t_seg);
         else if (off < 10) chk_out(name, 1'b0, 2'b00, 7'h00);
         else               chk_out(name, 1'b0, 2'b01, o_seg);
      end
   endtask

   initial begin
      vecs[0] = '{4'd4,  4'd2, 1'b0, 2'b10, 7'h66, 7'h5B};
      vecs[1] = '{4'd0,  4'd5, 1'b1, 2'b00, 7'h00, 7'h6D};
      vecs[2] = '{4'd0,  4'd5, 1'b0, 2'b10, 7'h3F, 7'h6D};
      vecs[3] = '{4'd12, 4'd8, 1'b0, 2'b10, 7'h40, 7'h7F};
      vecs[4] = '{4'd8,  4'd0, 1'b1, 2'b10, 7'h7F, 7'h3F};
      vecs[5] = '{4'd9,  4'd9, 1'b0, 2'b10, 7'h6F, 7'h6F};
      vecs[6] = '{4'd15, 4'd1, 1'b1, 2'b10, 7'h40, 7'h06};

      // Reset state, then release with enable high: frame_o after the first edge.
      zehner = 4'd4; einer = 4'd2;
      repeat (3) @(negedge clk);
      chk_out("reset_state", 1'b0, 2'b00, 7'h00);
      rst = 1'b0; en = 1'b1;
      @(negedge clk);
      chk_out("first_frame", 1'b1, 2'b00, 7'h00);
      check_frame("pattern_42_first", 2'b10, 7'h66, 7'h5B);

      for (int i = 0; i < 7; i++) begin
         zehner = vecs[i].z; einer = vecs[i].e; blank_lz = vecs[i].blz;
         wait_frame($sformatf("vec%0d_wait", i));
         check_frame($sformatf("vec%0d", i), vecs[i].t_dig, vecs[i].t_seg, vecs[i].o_seg);
      end

      // Mid-frame input change has no effect until the next latch.
      zehner = 4'd7; einer = 4'd3; blank_lz = 1'b0;
      wait_frame("hold_wait");
      for (int off = 1; off <= 11; off++) @(negedge clk);
      chk_out("hold_before", 1'b0, 2'b01, 7'h4F);
      zehner = 4'd9; einer = 4'd9;
      for (int off = 12; off < 16; off++) begin
         @(negedge clk);
         chk_out("hold_ones", 1'b0, 2'b01, 7'h4F);
      end
      @(negedge clk);
      check_frame("hold_new_frame", 2'b10, 7'h6F, 7'h6F);

      // Enable dropped mid-SHOW_T for 5 cycles; new digits picked up on re-enable.
      zehner = 4'd4; einer = 4'd2;
      wait_frame("en_wait");
      for (int off = 1; off <= 4; off++) @(negedge clk);
      chk_out("en_pre", 1'b0, 2'b10, 7'h66);
      en = 1'b0;
      zehner = 4'd3; einer = 4'd1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk_out("en_dark", 1'b0, 2'b00, 7'h00);
      end
      en = 1'b1;
      @(negedge clk);
      check_frame("en_restart", 2'b10, 7'h4F, 7'h06);

      // Asynchronous reset mid-SHOW_T, checked before any clock edge.
      wait_frame("rst_wait");
      for (int off = 1; off <= 4; off++) @(negedge clk);
      chk_out("rst_pre", 1'b0, 2'b10, 7'h4F);
      #2 rst = 1'b1;
      #1 chk_out("rst_async", 1'b0, 2'b00, 7'h00);
      @(negedge clk);
      chk_out("rst_held", 1'b0, 2'b00, 7'h00);
      rst = 1'b0;
      @(negedge clk);
      check_frame("rst_restart", 2'b10, 7'h4F, 7'h06);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
